// File: rtl/bram_clear_pkg.sv
// Shared types for the self-clearing block RAM.
package bram_clear_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic {
    PH_CLEAR = 1'b0,
    PH_RUN   = 1'b1
  } phase_e;

endpackage

// File: rtl/bram_core.sv
// Plain single-port read-first synchronous RAM with a registered, holdable read port.
module bram_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SIZE  = 1024,
  localparam int unsigned AW   = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Read-first: the output register captures the pre-write contents.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bram_clear.sv
// Block RAM that writes CLEAR_VALUE to every entry after reset, then serves
// one-cycle read-first user accesses.
module bram_clear
  import bram_clear_pkg::*;
#(
  parameter int unsigned     WIDTH       = 32,
  parameter int unsigned     SIZE        = 1024,
  parameter int unsigned     ADDR_LSH    = 2,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  output logic              o_initialized,
  input  logic              i_request,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_address,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_ready
);

  localparam int unsigned AW = $clog2(SIZE);
  localparam int unsigned CW = AW + 1;

  phase_e           phase_q, phase_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;

  logic             mem_we;
  logic             mem_re;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [AW-1:0]    user_idx;

  // Upper address bits beyond the index alias modulo SIZE.
  assign user_idx = AW'(i_address >> ADDR_LSH);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      phase_q <= PH_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Clear walks the counter over every entry; user traffic is ignored until RUN.
  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = user_idx;
    mem_wdata = i_wdata;
    case (phase_q)
      PH_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q[AW-1:0];
        mem_wdata = CLEAR_VALUE;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(SIZE - 1)) begin
          phase_d = PH_RUN;
        end
      end
      PH_RUN: begin
        if (i_request) begin
          mem_re  = 1'b1;
          mem_we  = i_rw;
          ready_d = 1'b1;
        end
      end
      default: begin
        phase_d = PH_CLEAR;
      end
    endcase
  end

  bram_core #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_core (
    .clk   (i_clock),
    .rst_n (i_reset),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (o_rdata)
  );

  assign o_initialized = (phase_q == PH_RUN);
  assign o_ready       = ready_q;

endmodule

// File: tb/tb_bram_clear.sv
// Scoreboard bench for bram_clear: WIDTH=64, SIZE=16, ADDR_LSH=2.
module tb_bram_clear;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned SIZE  = 16;
  localparam logic [WIDTH-1:0] CLR = 64'h0000_0000_ffff_fff0;

  logic              i_clock;
  logic              i_reset;
  logic              o_initialized;
  logic              i_request;
  logic              i_rw;
  logic [31:0]       i_address;
  logic [WIDTH-1:0]  i_wdata;
  logic [WIDTH-1:0]  o_rdata;
  logic              o_ready;

  bram_clear #(
    .WIDTH       (WIDTH),
    .SIZE        (SIZE),
    .ADDR_LSH    (2),
    .CLEAR_VALUE (CLR)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .o_initialized (o_initialized),
    .i_request     (i_request),
    .i_rw          (i_rw),
    .i_address     (i_address),
    .i_wdata       (i_wdata),
    .o_rdata       (o_rdata),
    .o_ready       (o_ready)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  int n_vec = 0;
  int n_err = 0;

  logic [WIDTH-1:0] mem_m [SIZE];
  logic [WIDTH-1:0] sb_q [$];
  logic [WIDTH-1:0] last_rdata;
  logic             model_run;
  logic             exp_ready;
  int               clr_cnt;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    model_run  = 1'b0;
    exp_ready  = 1'b0;
    clr_cnt    = 0;
    last_rdata = '0;
    sb_q.delete();
  endtask

  // One clock: drive, update model at the rising edge, compare at the falling edge.
  task automatic step(input logic req, input logic rw, input logic [31:0] addr,
                      input logic [WIDTH-1:0] wd);
    int idx;
    logic [WIDTH-1:0] exp_d;
    i_request = req;
    i_rw      = rw;
    i_address = addr;
    i_wdata   = wd;
    @(posedge i_clock);
    if (i_reset) begin
      if (model_run) begin
        if (req) begin
          idx = int'((addr >> 2) % SIZE);
          sb_q.push_back(mem_m[idx]);
          if (rw) mem_m[idx] = wd;
          exp_ready = 1'b1;
        end else begin
          exp_ready = 1'b0;
        end
      end else begin
        mem_m[clr_cnt] = CLR;
        clr_cnt++;
        if (clr_cnt == SIZE) model_run = 1'b1;
        exp_ready = 1'b0;
      end
    end
    @(negedge i_clock);
    check_val("init", 64'(o_initialized), 64'(model_run));
    check_val("ready", 64'(o_ready), 64'(exp_ready));
    if (exp_ready) begin
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 64'd1, 64'd0);
      end else begin
        exp_d = sb_q.pop_front();
        check_val("rdata", o_rdata, exp_d);
        last_rdata = exp_d;
      end
    end else begin
      check_val("rdata_hold", o_rdata, last_rdata);
    end
  endtask

  // Assert reset between edges, check outputs drop at once, hold two cycles, release.
  task automatic pulse_reset(input logic req, input logic rw);
    i_reset = 1'b0;
    #1;
    model_reset();
    check_val("rst_init", 64'(o_initialized), 64'd0);
    check_val("rst_ready", 64'(o_ready), 64'd0);
    check_val("rst_rdata", o_rdata, 64'd0);
    step(req, rw, 32'h14, 64'h1111_2222_3333_4444);
    step(req, rw, 32'h14, 64'h1111_2222_3333_4444);
    i_reset = 1'b1;
  endtask

  initial begin
    i_reset   = 1'b0;
    i_request = 1'b0;
    i_rw      = 1'b0;
    i_address = '0;
    i_wdata   = '0;
    model_reset();
    for (int i = 0; i < SIZE; i++) mem_m[i] = 'x;

    step(1'b0, 1'b0, 32'h0, '0);
    step(1'b0, 1'b0, 32'h0, '0);
    i_reset = 1'b1;

    // Clear phase with a write to index 0 that must be ignored.
    for (int i = 0; i < SIZE; i++) step(1'b1, 1'b1, 32'h0, 64'h1234);

    for (int i = 0; i < SIZE; i++) step(1'b1, 1'b0, 32'(i << 2), '0);

    step(1'b1, 1'b1, 32'h14, 64'hdead_beef_0000_0013);
    step(1'b1, 1'b0, 32'h14, '0);
    step(1'b1, 1'b0, 32'h54, '0);

    // Write then read of the same index on consecutive cycles.
    step(1'b1, 1'b1, 32'h24, 64'h0123_4567_89ab_cdef);
    step(1'b1, 1'b0, 32'h24, '0);

    step(1'b0, 1'b0, 32'h0, '0);
    step(1'b0, 1'b1, 32'h8, 64'hffff);
    step(1'b1, 1'b0, 32'h8, '0);

    for (int i = 0; i < 24; i++)
      step(1'b1, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom});

    // Reset mid-RUN with a write pending in the reset cycles.
    pulse_reset(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 32'h0, '0);

    // Reset mid-clear at edge 7.
    pulse_reset(1'b0, 1'b0);
    for (int i = 0; i < SIZE; i++) step(1'b0, 1'b0, 32'h0, '0);

    for (int i = 0; i < SIZE; i++) step(1'b1, 1'b0, 32'((SIZE - 1 - i) << 2), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
